// File: rtl/coherence_pkg.sv
// Shared MOESI coherence definitions: line state codes, snoop op codes,
// snoop-initiator FSM states and the default response timeout.
package coherence_pkg;

    typedef enum logic [2:0] {
        MOESI_M = 3'b000,
        MOESI_O = 3'b001,
        MOESI_E = 3'b010,
        MOESI_S = 3'b011,
        MOESI_I = 3'b100
    } moesi_e;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_RDX = 2'b01,
        OP_UPG = 2'b10,
        OP_RSV = 2'b11
    } snoop_op_e;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_SEND,
        FSM_WAIT,
        FSM_DONE
    } snoop_fsm_e;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/moesi_req_next_state.sv
// Maps a local request and the peer's snoop result to the state the local
// line installs and whether the fill data comes from the peer.
module moesi_req_next_state
    import coherence_pkg::*;
#(
    parameter int STATE_WIDTH = 3
) (
    input  logic [1:0]             op,
    input  logic                   hit,
    input  logic [STATE_WIDTH-1:0] peer_state,
    output logic [STATE_WIDTH-1:0] new_state,
    output logic                   data_from_peer
);

    logic w_peer_dirty;

    // Only a peer holding the line M or O has data newer than memory.
    assign w_peer_dirty = hit && ((peer_state == STATE_WIDTH'(MOESI_M)) ||
                                  (peer_state == STATE_WIDTH'(MOESI_O)));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        new_state      = STATE_WIDTH'(MOESI_I);
        data_from_peer = 1'b0;
        case (op)
            OP_RD: begin
                new_state      = hit ? STATE_WIDTH'(MOESI_S) : STATE_WIDTH'(MOESI_E);
                data_from_peer = w_peer_dirty;
            end
            OP_RDX: begin
                new_state      = STATE_WIDTH'(MOESI_M);
                data_from_peer = w_peer_dirty;
            end
            OP_UPG: begin
                new_state      = STATE_WIDTH'(MOESI_M);
            end
            default: begin
                new_state      = STATE_WIDTH'(MOESI_I);
            end
        endcase
    end

endmodule

// File: rtl/snoop_initiator.sv
// Issues one snoop per local miss/upgrade to the peer L1, waits for the
// response (or a timeout) and pulses the resulting local line state.
module snoop_initiator
    import coherence_pkg::*;
#(
    parameter int STATE_WIDTH = 3,
    parameter int TAG_WIDTH   = 22,
    parameter int INDEX_WIDTH = 8,
    parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   req_valid,
    input  logic [1:0]             req_op,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    input  logic [INDEX_WIDTH-1:0] req_index,
    output logic                   req_ready,
    output logic                   snp_valid,
    output logic [1:0]             snp_op,
    output logic [TAG_WIDTH-1:0]   snp_tag,
    output logic [INDEX_WIDTH-1:0] snp_index,
    input  logic                   snp_ready,
    input  logic                   rsp_valid,
    input  logic                   rsp_hit,
    input  logic [STATE_WIDTH-1:0] rsp_state,
    output logic                   done,
    output logic [STATE_WIDTH-1:0] new_state,
    output logic                   data_from_peer,
    output logic                   timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    snoop_fsm_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [1:0]             r_op;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [INDEX_WIDTH-1:0] r_index;
    logic                   r_req_ready;
    logic                   r_snp_valid;
    logic                   r_done;
    logic [STATE_WIDTH-1:0] r_new_state;
    logic                   r_data_from_peer;
    logic                   r_timeout;

    logic [1:0]             w_map_op;
    logic                   w_map_hit;
    logic [STATE_WIDTH-1:0] w_map_state;
    logic                   w_map_dfp;
    logic                   w_cnt_expired;

    // The reserved op resolves straight from IDLE, so the mapper sees the live
    // request there; otherwise it sees the latched op. A timeout is a miss.
    assign w_map_op      = (r_state == FSM_IDLE) ? req_op : r_op;
    assign w_map_hit     = (r_state == FSM_WAIT) && rsp_valid && rsp_hit;
    assign w_cnt_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

    moesi_req_next_state #(
        .STATE_WIDTH    (STATE_WIDTH)
    ) u_next_state (
        .op             (w_map_op),
        .hit            (w_map_hit),
        .peer_state     (rsp_state),
        .new_state      (w_map_state),
        .data_from_peer (w_map_dfp)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state          <= FSM_IDLE;
            r_cnt            <= '0;
            r_op             <= '0;
            r_tag            <= '0;
            r_index          <= '0;
            r_req_ready      <= 1'b1;
            r_snp_valid      <= 1'b0;
            r_done           <= 1'b0;
            r_new_state      <= STATE_WIDTH'(MOESI_I);
            r_data_from_peer <= 1'b0;
            r_timeout        <= 1'b0;
        end else begin
            // NOTE: these non-blocking defaults are overridden by any later
            // assignment below in the same cycle; the last one scheduled wins.
            r_done           <= 1'b0;
            r_new_state      <= STATE_WIDTH'(MOESI_I);
            r_data_from_peer <= 1'b0;
            r_timeout        <= 1'b0;
            case (r_state)
                FSM_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_tag       <= req_tag;
                        r_index     <= req_index;
                        r_req_ready <= 1'b0;
                        if (req_op == OP_RSV) begin
                            r_state     <= FSM_DONE;
                            r_done      <= 1'b1;
                            r_new_state <= w_map_state;
                        end else begin
                            r_state     <= FSM_SEND;
                            r_snp_valid <= 1'b1;
                        end
                    end
                end
                FSM_SEND: begin
                    if (snp_ready) begin
                        r_state     <= FSM_WAIT;
                        r_snp_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                FSM_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (rsp_valid || w_cnt_expired) begin
                        r_state          <= FSM_DONE;
                        r_done           <= 1'b1;
                        r_new_state      <= w_map_state;
                        r_data_from_peer <= w_map_dfp;
                        r_timeout        <= !rsp_valid;
                    end
                end
                default: begin
                    r_state     <= FSM_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Result fields idle at I / 0 whenever done is low.
    assign req_ready      = r_req_ready;
    assign snp_valid      = r_snp_valid;
    assign snp_op         = r_op;
    assign snp_tag        = r_tag;
    assign snp_index      = r_index;
    assign done           = r_done;
    assign new_state      = r_new_state;
    assign data_from_peer = r_data_from_peer;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_snoop_initiator.sv
// Directed bench for snoop_initiator: latency, MOESI mapping, stalls,
// timeout, reserved op, reset abort and back-to-back requests.
module tb_snoop_initiator;
    import coherence_pkg::*;

    localparam int SW = 3;
    localparam int TW = 22;
    localparam int IW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          req_valid;
    logic [1:0]    req_op;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_index;
    logic          req_ready;
    logic          snp_valid;
    logic [1:0]    snp_op;
    logic [TW-1:0] snp_tag;
    logic [IW-1:0] snp_index;
    logic          snp_ready;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [SW-1:0] rsp_state;
    logic          done;
    logic [SW-1:0] new_state;
    logic          data_from_peer;
    logic          timeout;

    int tests = 0;
    int fails = 0;

    snoop_initiator #(
        .STATE_WIDTH (SW),
        .TAG_WIDTH   (TW),
        .INDEX_WIDTH (IW),
        .TIMEOUT     (15)
    ) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_tag        (req_tag),
        .req_index      (req_index),
        .req_ready      (req_ready),
        .snp_valid      (snp_valid),
        .snp_op         (snp_op),
        .snp_tag        (snp_tag),
        .snp_index      (snp_index),
        .snp_ready      (snp_ready),
        .rsp_valid      (rsp_valid),
        .rsp_hit        (rsp_hit),
        .rsp_state      (rsp_state),
        .done           (done),
        .new_state      (new_state),
        .data_from_peer (data_from_peer),
        .timeout        (timeout)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Fast-path transaction: snp_ready high, response one cycle after SEND.
    task automatic run_txn(input string tag, input logic [1:0] op, input logic hit,
                           input logic [2:0] pst, input logic [2:0] exp_ns,
                           input logic exp_dfp);
        req_valid = 1'b1; req_op = op; req_tag = 22'h2A5A5A; req_index = 8'h3C;
        snp_ready = 1'b1;
        step();
        check({tag, "_send_valid"}, 32'(snp_valid), 32'd1);
        check({tag, "_send_fields"}, {snp_op, snp_tag, snp_index}, {op, 22'h2A5A5A, 8'h3C});
        req_valid = 1'b0;
        step();
        check({tag, "_wait_valid"}, 32'(snp_valid), 32'd0);
        rsp_valid = 1'b1; rsp_hit = hit; rsp_state = pst;
        step();
        check({tag, "_done"}, {done, new_state, data_from_peer, timeout},
              {1'b1, exp_ns, exp_dfp, 1'b0});
        rsp_valid = 1'b0;
        step();
        check({tag, "_idle"}, {done, new_state, data_from_peer, timeout, req_ready},
              {1'b0, 3'b100, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        int n;
        ARESETn = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_tag = '0; req_index = '0;
        snp_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0; rsp_state = 3'b000;
        step();
        step();
        check("reset_outputs", {req_ready, snp_valid, done, new_state, data_from_peer, timeout},
              {1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0});
        ARESETn = 1'b1;
        step();
        check("post_reset_ready", 32'(req_ready), 32'd1);

        // MOESI mapping on the 4-cycle fast path.
        run_txn("rd_hit_m",  2'b00, 1'b1, 3'b000, 3'b011, 1'b1);
        run_txn("rd_miss",   2'b00, 1'b0, 3'b000, 3'b010, 1'b0);
        run_txn("rd_hit_s",  2'b00, 1'b1, 3'b011, 3'b011, 1'b0);
        run_txn("rdx_hit_o", 2'b01, 1'b1, 3'b001, 3'b000, 1'b1);
        run_txn("rdx_miss",  2'b01, 1'b0, 3'b100, 3'b000, 1'b0);
        run_txn("upg_hit_o", 2'b10, 1'b1, 3'b001, 3'b000, 1'b0);

        // UPG with the peer stalling for 5 cycles.
        req_valid = 1'b1; req_op = 2'b10; req_tag = 22'h155AA1; req_index = 8'hE7;
        snp_ready = 1'b0;
        step();
        req_valid = 1'b0; req_tag = '0; req_index = '0;
        for (int i = 0; i < 5; i++) begin
            check("upg_stall_fields", {snp_valid, snp_op, snp_tag, snp_index},
                  {1'b1, 2'b10, 22'h155AA1, 8'hE7});
            if (i == 4) snp_ready = 1'b1;
            if (i < 4) step();
        end
        step();
        rsp_valid = 1'b1; rsp_hit = 1'b0; rsp_state = 3'b100;
        step();
        check("upg_stall_done", {done, new_state, timeout}, {1'b1, 3'b000, 1'b0});
        rsp_valid = 1'b0;
        step();

        // RDX with no response: timeout 15 cycles after WAIT entry.
        req_valid = 1'b1; req_op = 2'b01; snp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            n++;
        end
        check("timeout_latency", n, 32'd15);
        check("timeout_result", {done, new_state, data_from_peer, timeout},
              {1'b1, 3'b000, 1'b0, 1'b1});
        step();
        check("timeout_clears", {done, timeout}, {1'b0, 1'b0});

        // Response on the expiry cycle wins over the timeout.
        req_valid = 1'b1; req_op = 2'b00;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 14; i++) step();
        check("collide_not_yet", 32'(done), 32'd0);
        rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_state = 3'b000;
        step();
        check("collide_rsp_wins", {done, new_state, data_from_peer, timeout},
              {1'b1, 3'b011, 1'b1, 1'b0});
        rsp_valid = 1'b0;
        step();

        // Reserved op goes straight to DONE with I.
        req_valid = 1'b1; req_op = 2'b11;
        step();
        req_valid = 1'b0;
        check("rsv_done", {done, snp_valid, new_state, data_from_peer, timeout},
              {1'b1, 1'b0, 3'b100, 1'b0, 1'b0});
        step();
        check("rsv_idle", {done, req_ready}, {1'b0, 1'b1});

        // Reset during WAIT aborts silently; a stray response is ignored.
        req_valid = 1'b1; req_op = 2'b00;
        step();
        req_valid = 1'b0;
        step();
        step();
        ARESETn = 1'b0;
        #1;
        check("abort_async", {req_ready, snp_valid, done}, {1'b1, 1'b0, 1'b0});
        step();
        ARESETn = 1'b1;
        rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_state = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", {done, req_ready, snp_valid}, {1'b0, 1'b1, 1'b0});
        end
        rsp_valid = 1'b0;

        // Back-to-back: request held high is only taken again after DONE.
        req_valid = 1'b1; req_op = 2'b00; rsp_valid = 1'b1; rsp_hit = 1'b0;
        step();
        check("b2b_send", {req_ready, snp_valid}, {1'b0, 1'b1});
        step();
        check("b2b_wait", {req_ready, snp_valid}, {1'b0, 1'b0});
        step();
        check("b2b_done", {req_ready, done, new_state}, {1'b0, 1'b1, 3'b010});
        step();
        check("b2b_idle", {req_ready, snp_valid, done}, {1'b1, 1'b0, 1'b0});
        step();
        check("b2b_second_send", {req_ready, snp_valid}, {1'b0, 1'b1});
        req_valid = 1'b0;
        step();
        step();
        check("b2b_second_done", {done, new_state}, {1'b1, 3'b010});
        rsp_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/snoop_initiator.md
SNOOP_INITIATOR -- requirements
Module: snoop_initiator

Interface
REQ-001 Parameter STATE_WIDTH, default 3: width of a MOESI state code.
REQ-002 Parameter TAG_WIDTH, default 22: tag bits carried in a snoop.
REQ-003 Parameter INDEX_WIDTH, default 8: set-index bits carried in a snoop.
REQ-004 Parameter TIMEOUT, default 15: cycles WAIT tolerates before abandoning a response.
REQ-005 ACLK  in  1  single clock; every flop is rising-edge on ACLK.
REQ-006 ARESETn  in  1  reset, asynchronous assert and active-low.
REQ-007 req_valid  in  1  local L1 controller requests a snoop.
REQ-008 req_op  in  2  00 RD (read miss), 01 RDX (write miss), 10 UPG (write hit on S/O), 11 reserved.
REQ-009 req_tag / req_index  in  TAG_WIDTH / INDEX_WIDTH  line address.
REQ-010 req_ready  out  1  block idle and accepting a request.
REQ-011 snp_valid  out  1  snoop presented to peer L1.
REQ-012 snp_op / snp_tag / snp_index  out  2 / TAG_WIDTH / INDEX_WIDTH  registered copy of the request.
REQ-013 snp_ready  in  1  peer accepts the snoop.
REQ-014 rsp_valid  in  1  peer response strobe, one cycle.
REQ-015 rsp_hit / rsp_state  in  1 / STATE_WIDTH  peer hit flag and peer pre-snoop state.
REQ-016 done  out  1  one-cycle result pulse.
REQ-017 new_state  out  STATE_WIDTH  state the local line installs.
REQ-018 data_from_peer  out  1  fill data comes from peer rather than memory.
REQ-019 timeout  out  1  result was produced by timeout, not by a response.

Function
REQ-020 State codes: M=000, O=001, E=010, S=011, I=100.
REQ-021 FSM states IDLE, SEND, WAIT, DONE; reset state IDLE.
REQ-022 req_ready is 1 only in IDLE; req_valid&&req_ready latches op, tag and index and moves to SEND.
REQ-023 SEND drives snp_valid=1 with the latched fields stable until snp_ready; the handshake cycle moves to WAIT.
REQ-024 snp_valid is 0 in all states other than SEND.
REQ-025 WAIT clears a counter on entry and increments it each cycle; rsp_valid moves to DONE and captures rsp_hit/rsp_state.
REQ-026 With no rsp_valid, WAIT moves to DONE on the cycle the counter reaches TIMEOUT-1, treating the result as miss and setting timeout.
REQ-027 rsp_valid on the same cycle as the timeout count wins; timeout stays 0.
REQ-028 rsp_valid outside WAIT is ignored and changes no state.
REQ-029 DONE lasts one cycle with done=1, then returns to IDLE; new_state, data_from_peer and timeout are valid only while done=1 and are 0 otherwise.
REQ-030 RD: hit gives S, miss gives E.
REQ-031 RDX and UPG: new_state=M in all cases.
REQ-032 data_from_peer=1 only for RD/RDX with hit and rsp_state M or O.
REQ-033 Reserved op 11 skips SEND and WAIT and goes IDLE to DONE with new_state=I and data_from_peer=0.
REQ-034 Minimum latency with snp_ready=1 and a response the cycle after SEND: accept, SEND, WAIT, then done on the 4th cycle.
REQ-035 A req_valid arriving while busy is not accepted and holds until req_ready.

Reset
REQ-036 ARESETn low forces IDLE immediately, with counter=0, snp_valid=0, done=0, timeout=0, data_from_peer=0, new_state=I and req_ready=1 once released.
REQ-037 Reset mid-transaction discards it silently; no done pulse follows reset.

Structure
REQ-038 The MOESI codes, op codes, FSM state enum and the default TIMEOUT live in the shared coherence package, which the snoop checker also uses.
REQ-039 Next-state mapping (op, hit, peer state to new_state and data_from_peer) is one combinational sub-module, moesi_req_next_state; the FSM and counter stay in the top module.

Verification
REQ-040 RD, snp_ready=1, response hit=1 state=000 after 1 cycle -> done in 4th cycle, new_state=011, data_from_peer=1, timeout=0.
REQ-041 RD, response hit=0 -> new_state=010, data_from_peer=0.
REQ-042 UPG with snp_ready held low 5 cycles -> snp_valid=1 with fields stable for those 5 cycles, then done with new_state=000.
REQ-043 RDX, no response, TIMEOUT=15 -> done exactly 15 cycles after WAIT entry, timeout=1, new_state=000, data_from_peer=0.
REQ-044 ARESETn low during WAIT -> IDLE immediately, req_ready=1 after release, no done; a stray rsp_valid afterwards is ignored.
REQ-045 Back-to-back req_valid held high -> second request accepted in the cycle after done, never during the busy states.
